// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN_TO_BCD_BLANK_EN to blank leading zeros (code 4'hF) in digit2/digit1.
module bin_to_bcd_seq #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2
);

  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [3:0] LAST = 4'(WIDTH - 1);
`ifdef BIN_TO_BCD_BLANK_EN
  localparam logic [3:0] RST_HI = 4'hF;
`else
  localparam logic [3:0] RST_HI = 4'h0;
`endif

  state_t           state;
  logic [WIDTH-1:0] sh;
  logic [11:0]      bcd;
  logic [3:0]       cnt;
  logic             ovf_pending;

  logic             ovf_in;
  logic [3:0]       a0, a1;
  logic [2:0]       a2;
  logic [11:0]      bcd_nxt;
  logic [3:0]       out2, out1;

  // Bins above 999 cannot occur for WIDTH <= 9, so this folds to 0 there.
  assign ovf_in = {{(11-WIDTH){1'b0}}, bin_in} > 11'd999;

  // Hundreds nibble loses its MSB in the shift anyway, so only 3 bits are kept.
  always_comb begin
    a0 = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
    a1 = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
    a2 = (bcd[11:8] >= 4'd5) ? 3'(bcd[10:8] + 3'd3) : bcd[10:8];
    bcd_nxt = {a2, a1, a0, sh[WIDTH-1]};
  end

  always_comb begin
    out2 = bcd_nxt[11:8];
    out1 = bcd_nxt[7:4];
`ifdef BIN_TO_BCD_BLANK_EN
    if (bcd_nxt[11:8] == 4'd0) begin
      out2 = 4'hF;
      if (bcd_nxt[7:4] == 4'd0) out1 = 4'hF;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sh          <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
      digit2      <= RST_HI;
      digit1      <= RST_HI;
      digit0      <= 4'h0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh          <= bin_in;
          bcd         <= '0;
          cnt         <= '0;
          ovf_pending <= ovf_in;
          busy        <= 1'b1;
          state       <= CONV;
        end
        CONV: begin
          sh  <= {sh[WIDTH-2:0], 1'b0};
          bcd <= bcd_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (ovf_pending) begin
              digit2 <= 4'd9;
              digit1 <= 4'd9;
              digit0 <= 4'd9;
            end else begin
              digit2 <= out2;
              digit1 <= out1;
              digit0 <= bcd_nxt[3:0];
            end
            overflow <= ovf_pending;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed-vector bench for bin_to_bcd_seq (default WIDTH = 10).
module tb_bin_to_bcd_seq;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] bin_in = '0;
  logic       busy, done, overflow;
  logic [3:0] digit0, digit1, digit2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int bin;
    int d2, d1, d0;
    int ovf;
  } vec_t;

  vec_t vecs[10];

  bin_to_bcd_seq #(.WIDTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow),
    .digit0(digit0), .digit1(digit1), .digit2(digit2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Raw BCD expectations; blanking is applied here when the build enables it.
  task automatic expect_digits(input string name, input int e2, input int e1,
                               input int e0, input int eovf);
    int x2, x1;
    x2 = e2;
    x1 = e1;
`ifdef BIN_TO_BCD_BLANK_EN
    if (eovf == 0 && e2 == 0) begin
      x2 = 15;
      if (e1 == 0) x1 = 15;
    end
`endif
    chk({name, "_d2"}, int'(digit2), x2);
    chk({name, "_d1"}, int'(digit1), x1);
    chk({name, "_d0"}, int'(digit0), e0);
    chk({name, "_ovf"}, int'(overflow), eovf);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle where done is high.
  task automatic run(input string name, input int v, input int e2, input int e1,
                     input int e0, input int eovf);
    int lat;
    bit got;
    bin_in = 10'(v);
    start  = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_busy"}, int'(busy), 1);
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      step();
      lat++;
      if (done) got = 1;
    end
    chk({name, "_latency"}, lat, 10);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    expect_digits(name, e2, e1, e0, eovf);
  endtask

  initial begin
    int k, seen;

    vecs[0] = '{255,  2, 5, 5, 0};
    vecs[1] = '{1023, 9, 9, 9, 1};
    vecs[2] = '{42,   0, 4, 2, 0};
    vecs[3] = '{999,  9, 9, 9, 0};
    vecs[4] = '{0,    0, 0, 0, 0};
    vecs[5] = '{105,  1, 0, 5, 0};
    vecs[6] = '{7,    0, 0, 7, 0};
    vecs[7] = '{500,  5, 0, 0, 0};
    vecs[8] = '{100,  1, 0, 0, 0};
    vecs[9] = '{10,   0, 1, 0, 0};

    repeat (2) step();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    expect_digits("rst", 0, 0, 0, 0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].bin, vecs[i].d2, vecs[i].d1,
          vecs[i].d0, vecs[i].ovf);
      step();
      chk($sformatf("vec%0d_done_pulse", i), int'(done), 0);
      step();
      expect_digits($sformatf("vec%0d_hold", i), vecs[i].d2, vecs[i].d1,
                    vecs[i].d0, vecs[i].ovf);
    end

    // Back-to-back: second start lands in the done cycle of the first.
    run("b2b_999", 999, 9, 9, 9, 0);
    run("b2b_0", 0, 0, 0, 0, 0);
    step();

    // start held high with bin_in changing every cycle.
    for (int i = 0; i < 25; i++) begin
      bin_in = 10'(i * 40 + 3);
      start  = 1'b1;
      step();
      chk($sformatf("cont_done_%0d", i), int'(done), (i == 10 || i == 21) ? 1 : 0);
      if (i == 10) expect_digits("cont_first", 0, 0, 3, 0);
      if (i == 21) expect_digits("cont_second", 4, 4, 3, 0);
    end
    start = 1'b0;
    k = 0;
    while (k < 20 && !done) begin
      step();
      k++;
    end
    chk("cont_third_latency", k, 8);
    expect_digits("cont_third", 8, 8, 3, 0);
    step();

    // Reset in the middle of a conversion, with overflow and digits non-zero.
    run("pre_rst", 1023, 9, 9, 9, 1);
    step();
    bin_in = 10'd500;
    start  = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("mid_busy_before", int'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    expect_digits("mid_rst", 0, 0, 0, 0);
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done || busy) seen++;
    end
    chk("mid_rst_no_done", seen, 0);
    expect_digits("mid_rst_after", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
